// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry pipeline skid buffer with a valid/ready handshake on both sides.
//
// The head entry lives in main and drives out_data directly. The skid register catches one
// extra beat when the consumer stalls while the producer is still sending. The handshake
// outputs are registered, so in_ready and out_valid never depend combinationally on
// out_ready or in_valid.
//
// Ports
//   clk        in   clock, all state updates on its rising edge
//   r          in   asynchronous active-high reset
//   flush      in   synchronous clear of all held entries
//   in_valid   in   producer presents in_data
//   in_ready   out  buffer can accept in_data this cycle
//   in_data    in   producer payload, N bits
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  head-entry payload, N bits
//   occ        out  number of held entries, 0..2

module pipe_skid_buf #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         r,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occ
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e       r_state;
  logic [N-1:0] r_main;
  logic [N-1:0] r_skid;
  logic         r_out_valid;
  logic         r_in_ready;
  logic [1:0]   r_occ;

  state_e       w_state_d;
  logic [N-1:0] w_main_d;
  logic [N-1:0] w_skid_d;

  // Next-state and data-load decode. Registers hold unless a listed transition loads them.
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;

    unique case (r_state)
      StEmpty: begin
        if (in_valid) begin
          w_state_d = StOne;
          w_main_d  = in_data;
        end
      end
      StOne: begin
        if (in_valid && out_ready) begin
          // One beat leaves and one arrives in the same cycle.
          w_main_d = in_data;
        end else if (in_valid) begin
          w_state_d = StFull;
          w_skid_d  = in_data;
        end else if (out_ready) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so in_valid is ignored.
        if (out_ready) begin
          w_state_d = StOne;
          w_main_d  = r_skid;
        end
      end
      default: begin
        w_state_d = StEmpty;
      end
    endcase

    // Flush wins over every transition; anything accepted this cycle is dropped.
    if (flush) begin
      w_state_d = StEmpty;
      w_main_d  = '0;
      w_skid_d  = '0;
    end
  end

  // State, payload and handshake outputs all register together so the outputs are
  // always consistent with the state they describe.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state     <= StEmpty;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_d;
      r_main      <= w_main_d;
      r_skid      <= w_skid_d;
      r_out_valid <= (w_state_d != StEmpty);
      r_in_ready  <= (w_state_d != StFull);
      unique case (w_state_d)
        StEmpty: r_occ <= 2'd0;
        StOne:   r_occ <= 2'd1;
        StFull:  r_occ <= 2'd2;
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign occ       = r_occ;
  assign out_data  = r_main;

endmodule
